// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the I2C register slave.
// Glitch filtering is enabled by defining I2C_SLV_GLITCH_FILTER_EN.
package i2c_slv_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK
    } state_e;

    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;
    localparam int   BCNT_W = 3;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_slv_bus_filter.sv
// SCL/SDA synchronizers, optional 3-sample majority filter (I2C_SLV_GLITCH_FILTER_EN),
// and bus event pulses: SCL rise/fall, START, STOP.
module i2c_slv_bus_filter
    import i2c_slv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl_f, sda_f;

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, scl_hist_d;
    logic [2:0] sda_hist_q, sda_hist_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign scl_f = maj3(scl_hist_q);
    assign sda_f = maj3(sda_hist_q);
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_prev_d = scl_f;
        sda_prev_d = sda_f;
    end

    // Idle bus level is high, so everything resets to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda_o      = sda_f;
    assign scl_rise_o = scl_f & ~scl_prev_q;
    assign scl_fall_o = ~scl_f & scl_prev_q;
    assign start_o    = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_o     = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing NREGS byte registers via an auto-incrementing pointer.
// Optional SCL/SDA glitch filter: define I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_regs
    import i2c_slv_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h02,
    parameter int         NREGS    = 8,
    localparam int        PW       = $clog2(NREGS)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          scl_pad_i,
    input  logic          sda_pad_i,
    output logic          sda_pad_o,
    output logic          sda_padoen_o,
    input  logic [PW-1:0] reg_addr_i,
    output logic [7:0]    reg_dat_o,
    output logic          wr_stb_o,
    output logic [PW-1:0] wr_addr_o,
    output logic [7:0]    wr_dat_o,
    output logic          busy_o
);

    logic sda_f, scl_rise, scl_fall, start, stop;

    i2c_slv_bus_filter u_bus (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .scl_i      (scl_pad_i),
        .sda_i      (sda_pad_i),
        .sda_o      (sda_f),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    state_e            state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        tx_q, tx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              phase_q, phase_d;
    logic              oen_q, oen_d;
    logic              busy_q, busy_d;
    logic              wr_stb_q, wr_stb_d;
    logic [PW-1:0]     wr_addr_q, wr_addr_d;
    logic [7:0]        wr_dat_q, wr_dat_d;
    logic [7:0]        regs_q [NREGS];
    logic [7:0]        regs_d [NREGS];
    logic [7:0]        rx_byte, rd_byte;
    logic              load_rd;

    assign rx_byte = {shift_q, sda_f};
    assign rd_byte = regs_q[ptr_q];

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        phase_d   = phase_q;
        oen_d     = oen_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        regs_d    = regs_q;
        load_rd   = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            oen_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = ST_ADDR;
            bcnt_d  = '0;
            oen_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ADDR, ST_PTR, ST_WR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_W'(7)) begin
                            phase_d = 1'b0;
                            if (state_q == ST_ADDR) begin
                                // General call (address 0) is never acknowledged.
                                if (rx_byte[7:1] == SLV_ADDR && SLV_ADDR != 7'h00) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = sda_f;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IDLE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == ST_PTR) begin
                                state_d = ST_PTR_ACK;
                                ptr_d   = rx_byte[PW-1:0];
                            end else begin
                                state_d       = ST_WR_ACK;
                                regs_d[ptr_q] = rx_byte;
                                wr_stb_d      = 1'b1;
                                wr_addr_d     = ptr_q;
                                wr_dat_d      = rx_byte;
                                ptr_d         = ptr_q + 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    // First fall after bit 8 drives ACK; the fall ending bit 9 releases.
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oen_d   = ACK;
                            phase_d = 1'b1;
                        end else begin
                            oen_d  = 1'b1;
                            bcnt_d = '0;
                            if (state_q == ST_ADDR_ACK && rw_q) load_rd = 1'b1;
                            else if (state_q == ST_ADDR_ACK)    state_d = ST_PTR;
                            else                                state_d = ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    if (scl_rise) begin
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_W'(7)) begin
                            state_d = ST_RD_ACK;
                            phase_d = 1'b0;
                            ptr_d   = ptr_q + 1'b1;
                        end
                    end else if (scl_fall) begin
                        oen_d = tx_q[7];
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                end
                ST_RD_ACK: begin
                    if (scl_fall && !phase_q) begin
                        oen_d   = 1'b1;
                        phase_d = 1'b1;
                    end else if (scl_rise && phase_q && sda_f == NACK) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else if (scl_fall && phase_q) begin
                        load_rd = 1'b1;
                        bcnt_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (load_rd) begin
            state_d = ST_RD;
            oen_d   = rd_byte[7];
            tx_d    = {rd_byte[6:0], 1'b0};
        end
    end

    // NOTE: the register file is reset too, since its contents are architecturally 0 after reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            bcnt_q    <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            oen_q     <= 1'b1;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            oen_q     <= oen_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
            regs_q    <= regs_d;
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = oen_q;
    assign reg_dat_o    = regs_q[reg_addr_i];
    assign wr_stb_o     = wr_stb_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_dat_o     = wr_dat_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_slave_regs;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [2:0] reg_addr = '0;
    logic       sda_line;
    logic       sda_pad_o, sda_padoen_o, wr_stb_o, busy_o;
    logic [7:0] reg_dat_o, wr_dat_o;
    logic [2:0] wr_addr_o;

    int checks = 0;
    int failures = 0;
    int drive_cnt = 0;
    int busy_cnt = 0;
    int start_cnt = 0;
    logic [10:0] stb_log [$];

    always #5 clk = ~clk;

    assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

    i2c_slave_regs dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .scl_pad_i    (scl),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .reg_addr_i   (reg_addr),
        .reg_dat_o    (reg_dat_o),
        .wr_stb_o     (wr_stb_o),
        .wr_addr_o    (wr_addr_o),
        .wr_dat_o     (wr_dat_o),
        .busy_o       (busy_o)
    );

    always @(negedge clk) begin
        if (wr_stb_o) stb_log.push_back({wr_addr_o, wr_dat_o});
        if (sda_padoen_o === 1'b0) drive_cnt++;
        if (busy_o === 1'b1) busy_cnt++;
        if (dut.u_bus.start_o === 1'b1) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b; tick(Q);
        scl = 1'b1; tick(Q);
        s = sda_line; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(mack, s);
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        reg_addr = a;
        tick(1);
        check(tag, reg_dat_o, exp);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [7:0] d;
        logic [7:0] b;
        int         d0, b0, s0;

        tick(3);
        check("rst_padoen", sda_padoen_o, 1);
        check("rst_pad_o", sda_pad_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_stb", wr_stb_o, 0);
        check("rst_wr_addr", wr_addr_o, 0);
        check("rst_wr_dat", wr_dat_o, 0);
        check_reg("rst_reg4", 3'd4, 8'h00);
        rst_n = 1'b1;
        tick(4);

        // Pointer 4, two data bytes
        bus_start();
        write_byte(8'h04, a); check("w_addr_ack", a, 0);
        write_byte(8'h04, a); check("w_ptr_ack", a, 0);
        write_byte(8'hA5, a); check("w_d0_ack", a, 0);
        check("w_busy", busy_o, 1);
        write_byte(8'h5A, a); check("w_d1_ack", a, 0);
        bus_stop();
        tick(2);
        check("w_busy_after_stop", busy_o, 0);
        check("w_stb_count", stb_log.size(), 2);
        check("w_stb0", stb_log[0], {3'd4, 8'hA5});
        check("w_stb1", stb_log[1], {3'd5, 8'h5A});
        check_reg("w_reg4", 3'd4, 8'hA5);
        check_reg("w_reg5", 3'd5, 8'h5A);

        // Wrong address: never driven, never busy
        d0 = drive_cnt; b0 = busy_cnt;
        bus_start();
        write_byte(8'h06, a); check("na_addr_nack", a, 1);
        write_byte(8'h55, a); check("na_data_nack", a, 1);
        bus_stop();
        check("na_no_drive", drive_cnt - d0, 0);
        check("na_no_busy", busy_cnt - b0, 0);

        // Pointer write, repeated START, read two bytes
        bus_start();
        write_byte(8'h04, a); check("r_addr_ack", a, 0);
        write_byte(8'h04, a); check("r_ptr_ack", a, 0);
        bus_start();
        write_byte(8'h05, a); check("r_raddr_ack", a, 0);
        read_byte(1'b0, d); check("r_byte0", d, 8'hA5);
        read_byte(1'b1, d); check("r_byte1", d, 8'h5A);
        tick(2);
        check("r_idle_busy", busy_o, 0);
        check("r_idle_release", sda_padoen_o, 1);
        bus_stop();

        // Pointer wrap 7 -> 0, pointer persists into the next read
        bus_start();
        write_byte(8'h04, a); write_byte(8'h01, a); write_byte(8'h77, a);
        bus_stop();
        bus_start();
        write_byte(8'h04, a); write_byte(8'h07, a);
        write_byte(8'h11, a); check("wrap_d0_ack", a, 0);
        write_byte(8'h22, a); check("wrap_d1_ack", a, 0);
        bus_stop();
        check_reg("wrap_reg7", 3'd7, 8'h11);
        check_reg("wrap_reg0", 3'd0, 8'h22);
        check("wrap_stb", stb_log[4], {3'd0, 8'h22});
        bus_start();
        write_byte(8'h05, a);
        read_byte(1'b1, d); check("wrap_ptr_is_1", d, 8'h77);
        bus_stop();

        // STOP in the middle of a data byte
        s0 = stb_log.size();
        bus_start();
        write_byte(8'h04, a); write_byte(8'h02, a);
        clock_bit(1'b1, a); clock_bit(1'b1, a); clock_bit(1'b0, a); clock_bit(1'b0, a);
        bus_stop();
        tick(2);
        check("abort_no_stb", stb_log.size(), s0);
        check("abort_release", sda_padoen_o, 1);
        check("abort_idle", busy_o, 0);
        check_reg("abort_reg2", 3'd2, 8'h00);
        bus_start();
        write_byte(8'h04, a); check("abort_next_ack", a, 0);
        write_byte(8'h02, a);
        write_byte(8'h3C, a); check("abort_next_d_ack", a, 0);
        bus_stop();
        check_reg("abort_next_reg2", 3'd2, 8'h3C);

        // General call is not acknowledged
        bus_start();
        write_byte(8'h00, a); check("gcall_nack", a, 1);
        bus_stop();

        // Reset while the slave is driving ACK
        bus_start();
        b = 8'h04;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], a);
        check("mid_ack_driven", sda_padoen_o, 0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_release", sda_padoen_o, 1);
        check("mid_rst_busy", busy_o, 0);
        clock_bit(1'b1, a);
        write_byte(8'h04, a); check("mid_rst_ignored", a, 1);
        bus_stop();
        check_reg("mid_rst_reg4", 3'd4, 8'h00);

        // One-cycle SDA glitch while SCL is high
        tick(Q);
        s0 = start_cnt;
        sda_m = 1'b0;
        tick(1);
        sda_m = 1'b1;
        tick(3 * Q);
`ifdef I2C_SLV_GLITCH_FILTER_EN
        check("glitch_start", start_cnt - s0, 0);
`else
        check("glitch_start", start_cnt - s0, 1);
`endif
        check("glitch_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
